// File: rtl/carry_select_adder32_if.sv
// ---------------------------------------------------------------------------
// carry_select_adder32_if
//   Operand/result bundle for the registered 32-bit carry-select adder.
//
//   in1, in2  [31:0]  unsigned operands, sampled on the rising clock edge
//   sum       [31:0]  registered low 32 bits of in1 + in2
//   carryout          registered bit 32 of in1 + in2 (unsigned overflow)
//
//   master : drives the operands and observes the result (datapath / bench)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface carry_select_adder32_if;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [31:0] sum;
   logic        carryout;

   modport master (
      output in1,
      output in2,
      input  sum,
      input  carryout
   );

   modport slave (
      input  in1,
      input  in2,
      output sum,
      output carryout
   );
endinterface

// File: rtl/carry_select_adder32.sv
// ---------------------------------------------------------------------------
// carry_select_adder32
//   Single-cycle registered 32-bit unsigned adder. The combinational core
//   is split into eight 4-bit blocks: block 0 is a plain ripple adder with
//   carry-in 0, and blocks 1..7 each compute two ripple results (carry-in 0
//   and carry-in 1) in parallel so that the incoming block carry only has to
//   steer a mux. The 33-bit result is captured in the output flops.
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears sum and carryout
//   bus    : slave modport carrying in1/in2 (operands) and sum/carryout
// ---------------------------------------------------------------------------
module carry_select_adder32 (
   input  logic                   clk,
   input  logic                   rst_n,
   carry_select_adder32_if.slave  bus
);

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned BLK_W    = 4;
   localparam int unsigned NUM_BLKS = WIDTH / BLK_W;

   // 4-bit ripple adder built from full adders.
   // Returns {carry_out, sum[3:0]}. Plain bitwise operators are used so an
   // X/Z on any operand bit propagates into the result.
   function automatic logic [BLK_W:0] ripple4(
      input logic [BLK_W-1:0] a,
      input logic [BLK_W-1:0] b,
      input logic             ci
   );
      logic [BLK_W:0] res;
      logic           c;
      c = ci;
      for (int i = 0; i < BLK_W; i++) begin
         res[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      res[BLK_W] = c;
      return res;
   endfunction

   // blk_cout[k] is the carry out of block k, i.e. c(4k+4).
   logic [NUM_BLKS-1:0] blk_cout;
   logic [WIDTH-1:0]    sum_comb;

   logic [BLK_W:0]      blk0_res;

   assign blk0_res           = ripple4(bus.in1[BLK_W-1:0], bus.in2[BLK_W-1:0], 1'b0);
   assign sum_comb[BLK_W-1:0] = blk0_res[BLK_W-1:0];
   assign blk_cout[0]        = blk0_res[BLK_W];

   for (genvar k = 1; k < NUM_BLKS; k++) begin : g_sel_blk
      logic [BLK_W-1:0] a_slice;
      logic [BLK_W-1:0] b_slice;
      logic [BLK_W:0]   res_c0;
      logic [BLK_W:0]   res_c1;
      logic             c_in;

      assign a_slice = bus.in1[k*BLK_W +: BLK_W];
      assign b_slice = bus.in2[k*BLK_W +: BLK_W];
      assign c_in    = blk_cout[k-1];

      // Both candidate results settle while the lower carry is still
      // rippling in; the real carry only drives the select.
      assign res_c0 = ripple4(a_slice, b_slice, 1'b0);
      assign res_c1 = ripple4(a_slice, b_slice, 1'b1);

      assign sum_comb[k*BLK_W +: BLK_W] = c_in ? res_c1[BLK_W-1:0] : res_c0[BLK_W-1:0];

      // co1 is always >= co0, so OR-ing co0 with (co1 & c_in) gives the
      // block carry without a second mux on the carry chain.
      assign blk_cout[k] = res_c0[BLK_W] | (res_c1[BLK_W] & c_in);
   end

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         sum_q   <= sum_comb;
         carry_q <= blk_cout[NUM_BLKS-1];
      end
   end

   assign bus.sum      = sum_q;
   assign bus.carryout = carry_q;

endmodule

// File: tb/tb_carry_select_adder32.sv
module tb_carry_select_adder32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   carry_select_adder32_if bus ();

   carry_select_adder32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 33-bit addition of zero-extended operands.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic test_reset();
      // Load a non-zero result first so the asynchronous clear is visible.
      @(negedge clk);
      rst_n   = 1'b1;
      bus.in1 = 32'hFFFF_FFFF;
      bus.in2 = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      checks++;
      if (bus.sum !== 32'hFFFF_FFFE || bus.carryout !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_load: got sum=%h co=%b want sum=fffffffe co=1", bus.sum, bus.carryout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.sum !== 32'h0 || bus.carryout !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: got sum=%h co=%b want sum=00000000 co=0", bus.sum, bus.carryout);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.sum !== 32'h0 || bus.carryout !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold[%0d]: got sum=%h co=%b want sum=00000000 co=0", i, bus.sum, bus.carryout);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] vs [8];
      logic        vc [8];
      va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vs[0] = 32'h0000_0000; vc[0] = 1'b0;
      va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vs[1] = 32'hFFFF_FFFF; vc[1] = 1'b0;
      va[2] = 32'h0000_0000; vb[2] = 32'hFFFF_FFFF; vs[2] = 32'hFFFF_FFFF; vc[2] = 1'b0;
      va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vs[3] = 32'hFFFF_FFFE; vc[3] = 1'b1;
      va[4] = 32'h0000_000F; vb[4] = 32'h0000_0001; vs[4] = 32'h0000_0010; vc[4] = 1'b0;
      va[5] = 32'h7FFF_FFFF; vb[5] = 32'h0000_0001; vs[5] = 32'h8000_0000; vc[5] = 1'b0;
      va[6] = 32'hFFFF_FFFF; vb[6] = 32'h0000_0001; vs[6] = 32'h0000_0000; vc[6] = 1'b1;
      va[7] = 32'h0FFF_FFF0; vb[7] = 32'h0000_0010; vs[7] = 32'h1000_0000; vc[7] = 1'b0;
      // Release reset with the first pair already applied: the first
      // rising edge after release must register it.
      @(negedge clk);
      bus.in1 = va[0];
      bus.in2 = vb[0];
      rst_n   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) begin
            @(negedge clk);
            bus.in1 = va[i];
            bus.in2 = vb[i];
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.sum !== vs[i] || bus.carryout !== vc[i]) begin
            failures++;
            $display("FAIL directed[%0d] %h+%h: got sum=%h co=%b want sum=%h co=%b",
                     i, va[i], vb[i], bus.sum, bus.carryout, vs[i], vc[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [32:0] prev;
      logic [32:0] exp;
      logic [31:0] a;
      logic [31:0] b;
      prev = {bus.carryout, bus.sum};
      prev = ref_add(32'h0FFF_FFF0, 32'h0000_0010);
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         exp = ref_add(a, b);
         @(negedge clk);
         // Result of the previous pair must still be held mid-cycle.
         checks++;
         if ({bus.carryout, bus.sum} !== prev) begin
            failures++;
            $display("FAIL b2b_hold[%0d]: got %h want %h", i, {bus.carryout, bus.sum}, prev);
         end
         bus.in1 = a;
         bus.in2 = b;
         @(posedge clk);
         #1;
         checks++;
         if ({bus.carryout, bus.sum} !== exp) begin
            failures++;
            $display("FAIL b2b_result[%0d] %h+%h: got %h want %h", i, a, b, {bus.carryout, bus.sum}, exp);
         end
         prev = exp;
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic [32:0] exp;
      int          rst_idx;
      rst_idx = int'($urandom_range(2000, 8000));
      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(0, 7))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'hFFFF_FFFF - ($urandom & 32'h0000_00FF);
            default: a = $urandom;
         endcase
         b = $urandom;
         exp = ref_add(a, b);
         @(negedge clk);
         if (i == rst_idx) begin
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (bus.sum !== 32'h0 || bus.carryout !== 1'b0) begin
               failures++;
               $display("FAIL rand_reset_async: got sum=%h co=%b want sum=00000000 co=0", bus.sum, bus.carryout);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.sum !== 32'h0 || bus.carryout !== 1'b0) begin
               failures++;
               $display("FAIL rand_reset_hold: got sum=%h co=%b want sum=00000000 co=0", bus.sum, bus.carryout);
            end
            @(negedge clk);
            rst_n = 1'b1;
         end
         bus.in1 = a;
         bus.in2 = b;
         @(posedge clk);
         #1;
         checks++;
         if ({bus.carryout, bus.sum} !== exp) begin
            failures++;
            $display("FAIL random[%0d] %h+%h: got %h want %h", i, a, b, {bus.carryout, bus.sum}, exp);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      bus.in1  = 32'h0;
      bus.in2  = 32'h0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
